// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Holds the FSM state encoding, the 8N1 frame constants and the tick threshold
// formula, so that both directions derive identical timing from the same parameters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Last count value of the oversample tick counter (the counter runs 0..threshold).
  function automatic logic [31:0] tick_threshold(input logic [31:0] baudrate,
                                                 input logic [31:0] frequency,
                                                 input logic [31:0] oversample);
    return frequency / (baudrate * oversample) - 32'd1;
  endfunction

endpackage

// File: rtl/rx_oversample_tick_generator.sv
// Oversample tick generator for the UART receiver.
// Ports:
//   clk   - system clock
//   reset - synchronous active-low reset
//   clear - restarts the count from zero and suppresses the tick on that cycle
//   tick  - one-cycle pulse once every (threshold + 1) clocks
module rx_oversample_tick_generator
  import uart_pkg::*;
#(
  parameter logic [31:0] baudrate   = 32'd9600,
  parameter logic [31:0] frequency  = 32'd100000000,
  parameter logic [31:0] oversample = 32'd16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [31:0] THRESHOLD = tick_threshold(baudrate, frequency, oversample);

  logic [31:0] r_count;
  logic        r_tick;

  // Free-running counter, wraps at THRESHOLD and emits the tick on wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= 32'd0;
      r_tick  <= 1'b0;
    end else if (clear) begin
      r_count <= 32'd0;
      r_tick  <= 1'b0;
    end else if (r_count == THRESHOLD) begin
      r_count <= 32'd0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + 32'd1;
      r_tick  <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_rx_receiver.sv
// UART 8N1 receiver with 16x-style oversampling.
// Ports:
//   clk         - system clock
//   reset       - synchronous active-low reset
//   rx          - asynchronous serial input, idles high
//   rx_data     - last correctly framed byte, held until the next good frame
//   rx_valid    - one-cycle pulse when rx_data updates
//   frame_error - one-cycle pulse when the stop bit samples low
//   busy        - high from start-edge detection until frame completion or abort
module uart_rx_receiver
  import uart_pkg::*;
#(
  parameter logic [31:0] baudrate   = 32'd9600,
  parameter logic [31:0] frequency  = 32'd100000000,
  parameter logic [31:0] oversample = 32'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned       TICK_W    = $clog2(oversample);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(oversample / 32'd2 - 32'd1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(oversample - 32'd1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  uart_state_e       r_state;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_error;
  logic              r_busy;

  logic w_rx;
  logic w_start_edge;
  logic w_clear;
  logic w_tick;

  assign w_rx         = r_sync2;
  // Only a genuine high-to-low transition starts a frame; a held-low line never retriggers.
  assign w_start_edge = r_prev & ~r_sync2;
  // Phase-align the tick counter to the start edge so samples land mid-bit.
  assign w_clear      = (r_state == IDLE) && w_start_edge;

  rx_oversample_tick_generator #(
    .baudrate  (baudrate),
    .frequency (frequency),
    .oversample(oversample)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(w_clear),
    .tick (w_tick)
  );

  // Synchroniser, receive FSM, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_prev        <= 1'b1;
      r_state       <= IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_sync1       <= rx;
      r_sync2       <= r_sync1;
      r_prev        <= r_sync2;
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;

      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (w_start_edge) begin
            r_tick_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= START;
          end
        end

        // Re-check the line in the middle of the start bit to reject glitches.
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == HALF_LAST) begin
              if (!w_rx) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= 3'd0;
                r_state    <= DATA;
              end else begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        // LSB arrives first, so shift right and insert at the top.
        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx, r_shift[7:1]};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == LAST_BIT) begin
                r_state <= STOP;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        // Decide at mid stop bit, leaving half a bit to catch a back-to-back start.
        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
              if (w_rx) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
              end else begin
                r_frame_error <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_receiver.sv
// Directed self-checking bench for uart_rx_receiver.
// Bench timing: baudrate=1, frequency=160, oversample=16 -> 10 clk per tick, 160 clk per bit.
module tb_uart_rx_receiver;

  localparam int BIT_CLK  = 160;
  localparam int TICK_CLK = 10;
  // Start edge to strobe: 2 clk synchroniser + (8 + 128 + 16) ticks.
  localparam int LAT_NOM  = 2 + (8 + 8 * 16 + 16) * TICK_CLK;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [7:0] v_data[$];
  int         v_time[$];
  int         fe_total       = 0;
  int         busy_cyc       = 0;
  int         both_cnt       = 0;
  int         wide_cnt       = 0;
  int         busy_at_strobe = 0;
  logic       prev_v         = 1'b0;
  logic       prev_fe        = 1'b0;

  always #5 clk = ~clk;

  uart_rx_receiver #(
    .baudrate  (32'd1),
    .frequency (32'd160),
    .oversample(32'd16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      v_data.push_back(rx_data);
      v_time.push_back(cyc);
      if (busy) busy_at_strobe++;
    end
    if (frame_error) fe_total++;
    if (busy) busy_cyc++;
    if (rx_valid && frame_error) both_cnt++;
    if ((rx_valid && prev_v) || (frame_error && prev_fe)) wide_cnt++;
    prev_v  = rx_valid;
    prev_fe = frame_error;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] vd(input int i);
    if (i < v_data.size()) return v_data[i];
    return 8'hxx;
  endfunction

  function automatic int vt(input int i);
    if (i < v_time.size()) return v_time[i];
    return -100000;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    int base;
    int fe0;
    int b0;
    int st;
    int lat;
    int gap;
    logic [7:0] pre;

    // Reset with rx toggling
    for (int i = 0; i < 3; i++) begin
      rx = (i % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      check("rst_data",  32'(rx_data),     32'h00);
      check("rst_valid", 32'(rx_valid),    32'h0);
      check("rst_fe",    32'(frame_error), 32'h0);
      check("rst_busy",  32'(busy),        32'h0);
    end
    rx = 1'b1;
    wait_clk(1);
    reset = 1'b1;
    wait_clk(40);
    check("idle_busy",    32'(busy), 32'h0);
    check("idle_strobes", 32'(v_data.size() + fe_total), 32'd0);

    // Single frame 8'hA5
    base = v_data.size();
    fe0  = fe_total;
    st   = cyc;
    send_frame(8'hA5, 1'b1);
    wait_clk(BIT_CLK);
    check("a5_count", 32'(v_data.size() - base), 32'd1);
    check("a5_data",  32'(vd(base)), 32'hA5);
    lat = vt(base) - st;
    check("a5_latency", 32'((lat >= LAT_NOM - TICK_CLK) && (lat <= LAT_NOM + TICK_CLK)), 32'd1);
    check("a5_fe",    32'(fe_total - fe0), 32'd0);
    check("a5_busy",  32'(busy), 32'h0);

    // Back-to-back 8'h00 then 8'hFF
    base = v_data.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clk(BIT_CLK);
    check("b2b_count", 32'(v_data.size() - base), 32'd2);
    check("b2b_data0", 32'(vd(base)),     32'h00);
    check("b2b_data1", 32'(vd(base + 1)), 32'hFF);
    gap = vt(base + 1) - vt(base);
    check("b2b_gap", 32'((gap >= 10 * BIT_CLK - TICK_CLK) && (gap <= 10 * BIT_CLK + TICK_CLK)), 32'd1);

    // Framing error on 8'h3C, then a stuck-low line, then recovery with 8'h81
    base = v_data.size();
    fe0  = fe_total;
    pre  = 8'hFF;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    wait_clk(5 * BIT_CLK);
    check("fe_count",   32'(fe_total - fe0), 32'd1);
    check("fe_novalid", 32'(v_data.size() - base), 32'd0);
    check("fe_hold",    32'(rx_data), 32'(pre));
    check("fe_busy",    32'(busy), 32'h0);
    rx = 1'b1;
    wait_clk(BIT_CLK);
    send_frame(8'h81, 1'b1);
    wait_clk(BIT_CLK);
    check("rec_count", 32'(v_data.size() - base), 32'd1);
    check("rec_data",  32'(vd(base)), 32'h81);
    check("rec_fe",    32'(fe_total - fe0), 32'd1);

    // 40-clk glitch on idle line
    base = v_data.size();
    fe0  = fe_total;
    b0   = busy_cyc;
    rx = 1'b0;
    wait_clk(40);
    rx = 1'b1;
    wait_clk(200);
    check("gl_busy_len", 32'(((busy_cyc - b0) >= 70) && ((busy_cyc - b0) <= 90)), 32'd1);
    check("gl_busy_end", 32'(busy), 32'h0);
    check("gl_strobes",  32'((v_data.size() - base) + (fe_total - fe0)), 32'd0);

    // Reset during bit 4 of 8'h96, then receive 8'h5A
    base = v_data.size();
    fe0  = fe_total;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    wait_clk(BIT_CLK / 2);
    reset = 1'b0;
    wait_clk(3);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_data", 32'(rx_data), 32'h00);
    reset = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("mr_strobes", 32'((v_data.size() - base) + (fe_total - fe0)), 32'd0);
    check("mr_idle",    32'(busy), 32'h0);
    send_frame(8'h5A, 1'b1);
    wait_clk(BIT_CLK);
    check("5a_count", 32'(v_data.size() - base), 32'd1);
    check("5a_data",  32'(vd(base)), 32'h5A);
    check("5a_fe",    32'(fe_total - fe0), 32'd0);

    // Strobe shape invariants over the whole run
    check("both_high",      32'(both_cnt), 32'd0);
    check("strobe_width",   32'(wide_cnt), 32'd0);
    check("busy_at_strobe", 32'(busy_at_strobe), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
